// File: rtl/pulse_meter.sv
// Pulse meter: synchronizes sig_in and measures high time and rise-to-rise period
// in clk_ cycles, presenting each completed measurement on a valid/ready port.
module pulse_meter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic             clk_,
    input  logic             reset_,
    input  logic             en,
    input  logic             sig_in,
    input  logic             clr_err,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_sat,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic             r_s_d, r_rise, r_fall;
    logic             w_s, w_edge;
    logic [CNT_W-1:0] r_hcnt, r_pcnt, r_tcnt;
    logic [CNT_W-1:0] w_hcnt_nxt, w_pcnt_nxt, w_tcnt_nxt;
    logic [CNT_W-1:0] w_hcnt_inc, w_pcnt_inc;
    logic             w_h_at_max, w_p_at_max;
    logic             r_sat, w_sat_nxt;
    logic             w_done, w_expire;
    logic             r_valid, r_msat, r_timeout, r_overrun;
    logic [CNT_W-1:0] r_high, r_period;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_edge = r_rise | r_fall;

    // Edges are registered so the FSM sees them SYNC_STAGES+1 cycles after sig_in moves.
    always_ff @(posedge clk_ or negedge reset_) begin
        if (!reset_) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_d  <= w_s;
            r_rise <= w_s & ~r_s_d;
            r_fall <= ~w_s & r_s_d;
        end
    end

    assign w_h_at_max = (r_hcnt == CNT_MAX);
    assign w_p_at_max = (r_pcnt == CNT_MAX);
    assign w_hcnt_inc = w_h_at_max ? r_hcnt : r_hcnt + CNT_W'(1);
    assign w_pcnt_inc = w_p_at_max ? r_pcnt : r_pcnt + CNT_W'(1);

    always_ff @(posedge clk_ or negedge reset_) begin
        if (!reset_) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_pcnt  <= '0;
            r_tcnt  <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_pcnt_nxt  = r_pcnt;
        w_tcnt_nxt  = r_tcnt;
        w_sat_nxt   = r_sat;
        w_done      = 1'b0;
        w_expire    = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_hcnt_nxt  = '0;
            w_pcnt_nxt  = '0;
            w_tcnt_nxt  = '0;
            w_sat_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_rise) begin
                        w_state_nxt = ST_HIGH;
                        w_hcnt_nxt  = CNT_W'(1);
                        w_pcnt_nxt  = CNT_W'(1);
                        w_tcnt_nxt  = '0;
                        w_sat_nxt   = 1'b0;
                    end
                end
                ST_HIGH, ST_LOW: begin
                    // An edge arriving in the expiry cycle wins over the timeout.
                    if (!w_edge && (r_tcnt == TO_LAST)) begin
                        w_expire    = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_hcnt_nxt  = '0;
                        w_pcnt_nxt  = '0;
                        w_tcnt_nxt  = '0;
                        w_sat_nxt   = 1'b0;
                    end else begin
                        w_tcnt_nxt = w_edge ? '0 : r_tcnt + CNT_W'(1);
                        if (r_state == ST_HIGH) begin
                            w_pcnt_nxt = w_pcnt_inc;
                            w_sat_nxt  = r_sat | w_p_at_max;
                            if (r_fall) begin
                                w_state_nxt = ST_LOW;
                            end else begin
                                w_hcnt_nxt = w_hcnt_inc;
                                w_sat_nxt  = r_sat | w_p_at_max | w_h_at_max;
                            end
                        end else if (r_rise) begin
                            w_done      = 1'b1;
                            w_state_nxt = ST_HIGH;
                            w_hcnt_nxt  = CNT_W'(1);
                            w_pcnt_nxt  = CNT_W'(1);
                            w_sat_nxt   = 1'b0;
                        end else begin
                            w_pcnt_nxt = w_pcnt_inc;
                            w_sat_nxt  = r_sat | w_p_at_max;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ or negedge reset_) begin
        if (!reset_) begin
            r_valid   <= 1'b0;
            r_high    <= '0;
            r_period  <= '0;
            r_msat    <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_done && (!r_valid || meas_ready)) begin
                r_valid  <= 1'b1;
                r_high   <= r_hcnt;
                r_period <= r_pcnt;
                r_msat   <= r_sat;
            end else if (r_valid && meas_ready) begin
                r_valid <= 1'b0;
            end
            if (w_done && r_valid && !meas_ready) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign meas_valid  = r_valid;
    assign meas_high   = r_high;
    assign meas_period = r_period;
    assign meas_sat    = r_msat;
    assign timeout     = r_timeout;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: two instances (default and CNT_W=4/TIMEOUT=15) checked
// every cycle against an edge-time reference model with handshake bookkeeping.
module tb_pulse_meter;

    localparam int S0 = 2, TO0 = 65535, MX0 = 65535;
    localparam int S1 = 3, TO1 = 15,    MX1 = 15;

    logic        clk_ = 1'b0;
    logic        reset_, en, sig_in, clr_err, meas_ready;
    logic        v0, sat0, to0, ov0, v1, sat1, to1, ov1;
    logic [15:0] h0, p0;
    logic [3:0]  h1, p1;

    pulse_meter #(.SYNC_STAGES(S0), .CNT_W(16), .TIMEOUT(TO0)) u_dut0 (
        .clk_(clk_), .reset_(reset_), .en(en), .sig_in(sig_in), .clr_err(clr_err),
        .meas_valid(v0), .meas_ready(meas_ready), .meas_high(h0), .meas_period(p0),
        .meas_sat(sat0), .timeout(to0), .overrun(ov0));

    pulse_meter #(.SYNC_STAGES(S1), .CNT_W(4), .TIMEOUT(TO1)) u_dut1 (
        .clk_(clk_), .reset_(reset_), .en(en), .sig_in(sig_in), .clr_err(clr_err),
        .meas_valid(v1), .meas_ready(meas_ready), .meas_high(h1), .meas_period(p1),
        .meas_sat(sat1), .timeout(to1), .overrun(ov1));

    always #5 clk_ = ~clk_;

    int cyc = 0;
    logic en_seen = 1'b0, rdy_seen = 1'b0, clr_seen = 1'b0;
    always @(posedge clk_) begin
        cyc      <= cyc + 1;
        en_seen  <= en;
        rdy_seen <= meas_ready;
        clr_seen <= clr_err;
    end

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: sig_in edges are scheduled at the cycle the FSM acts on them.
    typedef struct { int m; int a; bit lvl; } ev_t;
    ev_t evq[$];
    int  SS[2] = '{S0, S1};
    int  TT[2] = '{TO0, TO1};
    int  MX[2] = '{MX0, MX1};
    bit  armed[2], got_fall[2], mv[2], ms[2], movr[2], mto[2];
    int  rise_a[2], fall_a[2], last_a[2], mh[2], mp[2];
    int  first_v[2], to_cnt[2], v_cnt[2], last_h[2], last_p[2], last_s[2];
    bit  mon_on = 1'b0;

    task automatic model_reset();
        evq.delete();
        for (int m = 0; m < 2; m++) begin
            armed[m] = 0; got_fall[m] = 0; mv[m] = 0; ms[m] = 0; movr[m] = 0; mto[m] = 0;
            mh[m] = 0; mp[m] = 0;
        end
    endtask

    task automatic model_step(input int m);
        bit ev = 0, lvl = 0, done = 0, ovr_new = 0;
        int h = 0, p = 0;
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].m == m) begin
                if (evq[i].a == cyc) begin
                    ev = 1; lvl = evq[i].lvl; evq.delete(i);
                end
                break;
            end
        end
        mto[m] = 0;
        if (!en_seen) begin
            armed[m] = 0;
        end else if (ev) begin
            if (lvl) begin
                if (armed[m] && got_fall[m]) begin
                    done = 1; h = fall_a[m] - rise_a[m]; p = cyc - rise_a[m];
                end
                armed[m] = 1; got_fall[m] = 0; rise_a[m] = cyc; last_a[m] = cyc;
            end else if (armed[m]) begin
                got_fall[m] = 1; fall_a[m] = cyc; last_a[m] = cyc;
            end
        end else if (armed[m] && cyc == last_a[m] + TT[m]) begin
            mto[m] = 1; armed[m] = 0;
        end
        if (done) begin
            if (!mv[m] || rdy_seen) begin
                mv[m] = 1;
                ms[m] = (h > MX[m]) || (p > MX[m]);
                mh[m] = (h > MX[m]) ? MX[m] : h;
                mp[m] = (p > MX[m]) ? MX[m] : p;
            end else begin
                ovr_new = 1;
            end
        end else if (mv[m] && rdy_seen) begin
            mv[m] = 0;
        end
        if (ovr_new) movr[m] = 1;
        else if (clr_seen) movr[m] = 0;
    endtask

    task automatic cmp(input int m, input logic v, input logic [15:0] h, input logic [15:0] p,
                       input logic s, input logic to, input logic ov);
        check($sformatf("valid%0d", m), v, mv[m]);
        check($sformatf("timeout%0d", m), to, mto[m]);
        check($sformatf("overrun%0d", m), ov, movr[m]);
        if (mv[m]) begin
            check($sformatf("high%0d", m), h, mh[m]);
            check($sformatf("period%0d", m), p, mp[m]);
            check($sformatf("sat%0d", m), s, ms[m]);
        end
        if (v && first_v[m] == 0) first_v[m] = cyc;
        if (v) begin
            v_cnt[m]++; last_h[m] = h; last_p[m] = p; last_s[m] = s;
        end
        if (to) to_cnt[m]++;
    endtask

    always @(negedge clk_) begin
        if (mon_on) begin
            model_step(0); cmp(0, v0, h0, p0, sat0, to0, ov0);
            model_step(1); cmp(1, v1, {12'd0, h1}, {12'd0, p1}, sat1, to1, ov1);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_); #1; end
    endtask

    task automatic set_sig(input bit lvl);
        if (lvl != sig_in) begin
            evq.push_back('{0, cyc + S0 + 2, lvl});
            evq.push_back('{1, cyc + S1 + 2, lvl});
        end
        sig_in = lvl;
    endtask

    task automatic pulse_train(input int hi, input int lo, input int n);
        repeat (n) begin
            set_sig(1); tick(hi);
            set_sig(0); tick(lo);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_v0"}, v0, 0);    check({pfx, "_h0"}, h0, 0);  check({pfx, "_p0"}, p0, 0);
        check({pfx, "_s0"}, sat0, 0);  check({pfx, "_t0"}, to0, 0); check({pfx, "_o0"}, ov0, 0);
        check({pfx, "_v1"}, v1, 0);    check({pfx, "_h1"}, h1, 0);  check({pfx, "_p1"}, p1, 0);
        check({pfx, "_s1"}, sat1, 0);  check({pfx, "_t1"}, to1, 0); check({pfx, "_o1"}, ov1, 0);
    endtask

    task automatic restart_en();
        en = 0; tick(3); en = 1; tick(1);
    endtask

    int t1, vsnap;

    initial begin
        reset_ = 0; en = 0; sig_in = 0; clr_err = 0; meas_ready = 1;
        model_reset();
        tick(3);
        reset_ = 1; mon_on = 1;
        check_zero("rst");
        en = 1; tick(1);

        // 3 high / 5 low: valid every 8 cycles with (3, 8, 0)
        pulse_train(3, 5, 6);
        tick(1);
        check("t1_high", last_h[0], 3);
        check("t1_period", last_p[0], 8);
        check("t1_vcnt", v_cnt[0], 5);

        // 1-cycle strobe every 4 cycles, first-valid latency
        restart_en();
        first_v = '{0, 0};
        t1 = cyc;
        pulse_train(1, 3, 6);
        check("lat0", first_v[0] - (t1 + 4), S0 + 2);
        check("lat1", first_v[1] - (t1 + 4), S1 + 2);
        check("t2_high", last_h[0], 1);
        check("t2_period", last_p[0], 4);

        // overrun with the consumer stalled
        restart_en();
        meas_ready = 0;
        pulse_train(3, 5, 3);
        set_sig(1); tick(S1 + 3);
        @(negedge clk_);
        check("hold_v", v0, 1); check("hold_h", h0, 3); check("hold_p", p0, 8);
        check("ovr_set", ov0, 1);
        meas_ready = 1;
        @(posedge clk_); #1; meas_ready = 0;
        @(negedge clk_);
        check("xfer_v", v0, 0);
        clr_err = 1;
        @(posedge clk_); #1; clr_err = 0;
        @(negedge clk_);
        check("ovr_clr", ov0, 0);
        tick(1);
        set_sig(0); meas_ready = 1; tick(4);

        // small instance: long high times out, then saturating period
        restart_en();
        to_cnt[1] = 0; vsnap = v_cnt[1];
        set_sig(1); tick(20); set_sig(0); tick(12);
        check("to_pulses", to_cnt[1], 1);
        check("to_novalid", v_cnt[1], vsnap);
        pulse_train(10, 10, 3);
        tick(6);
        check("sat_high", last_h[1], 10);
        check("sat_period", last_p[1], 15);
        check("sat_flag", last_s[1], 1);

        // asynchronous reset mid-HIGH with a pending result
        restart_en();
        meas_ready = 0;
        pulse_train(3, 5, 1);
        set_sig(1); tick(S0 + 4);
        check("pre_rst_v", v0, 1);
        #3; mon_on = 0; reset_ = 0;
        #1; check_zero("arst");
        model_reset(); sig_in = 0;
        tick(2);
        meas_ready = 1; reset_ = 1; mon_on = 1;
        first_v = '{0, 0};
        t1 = cyc;
        pulse_train(3, 5, 3);
        check("rel_lat0", first_v[0] - (t1 + 8), S0 + 2);

        // en dropped mid-LOW: no spurious measurement, two new rises needed
        set_sig(1); tick(3); set_sig(0); tick(8);
        en = 0; tick(3); en = 1;
        first_v = '{0, 0};
        tick(5);
        t1 = cyc;
        pulse_train(2, 4, 3);
        tick(6);
        check("en_lat0", first_v[0] - (t1 + 6), S0 + 2);
        check("en_lat1", first_v[1] - (t1 + 6), S1 + 2);
        check("en_high", last_h[0], 2);
        check("en_period", last_p[0], 6);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            meas_ready = ($urandom_range(0, 3) != 0);
            clr_err    = ($urandom_range(0, 9) == 0);
            en         = ($urandom_range(0, 24) != 0);
            set_sig(1); tick($urandom_range(1, 9));
            meas_ready = ($urandom_range(0, 3) != 0);
            set_sig(0); tick($urandom_range(1, 18));
        end
        en = 1; meas_ready = 1; clr_err = 0;
        tick(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Synthesizable measurement block for pulse-type control signals, e.g. strobes, tick enables and externally sourced resets.
- Synchronizes an asynchronous single-bit input and measures its high time and rise-to-rise period in `clk_` cycles.
- Presents each completed measurement on a valid/ready output port.
- Sits on the receive side of any pulse or periodic-strobe interface, as a monitor, a frequency/duty checker, or a debug tap.

Parameters:
- SYNC_STAGES, 2: number of flops in the input synchronizer, minimum 2.
- CNT_W, 16: width of the measurement counters and outputs.
- TIMEOUT, 65535: cycles without a detected edge before a measurement is abandoned. Range 1 to 2^CNT_W-1.

Ports:
- clk_  input  1  single clock; all logic on its rising edge.
- reset_  input  1  asynchronous active-low reset.
- en  input  1  measurement enable (synchronous).
- sig_in  input  1  asynchronous signal under measurement.
- clr_err  input  1  synchronous clear of the overrun flag.
- meas_valid  output  1  measurement available.
- meas_ready  input  1  consumer accepts the measurement.
- meas_high  output  CNT_W  high time, in cycles.
- meas_period  output  CNT_W  rise-to-rise period, in cycles.
- meas_sat  output  1  one or both counters saturated during this measurement.
- timeout  output  1  one-cycle pulse: measurement abandoned.
- overrun  output  1  sticky: a completed measurement was dropped.

Behaviour:
- **Reset.** `reset_` low asynchronously clears everything:
  - synchronizer, edge register and all counters to 0;
  - FSM to IDLE;
  - all outputs to 0.
  - Reset mid-measurement discards the measurement in progress, including any pending `meas_valid`.
- **Synchronizer and edge detect.**
  - `s` is the last synchronizer stage; `s_d` is `s` delayed one cycle.
  - `rise` = `s & ~s_d`; `fall` = `~s & s_d`.
  - Latency from an `sig_in` change to `rise`/`fall` is SYNC_STAGES+1 cycles.
- **FSM states:** IDLE, HIGH, LOW.
  - IDLE, `rise` → HIGH. Set `hcnt`=1, `pcnt`=1, `tcnt`=0. No output is produced (the first edge only arms the block).
  - HIGH, each cycle: `hcnt`++ and `pcnt`++.
  - HIGH, on `fall` → LOW. `pcnt`++ and `hcnt` held.
  - LOW, each cycle: `pcnt`++.
  - LOW, on `rise` → HIGH:
    - complete a measurement of (`hcnt`, `pcnt`, `sat`);
    - in the same cycle restart with `hcnt`=1, `pcnt`=1, `sat`=0 (back-to-back measurements, no dead cycle).
  - `en`=0 in any state → IDLE with counters cleared. A pending `meas_valid` is held until accepted.
- **Counters.**
  - `hcnt` and `pcnt` saturate at 2^CNT_W-1 and never wrap.
  - Any saturating increment sets the internal `sat` flag for the current measurement.
- **Timeout.**
  - `tcnt` clears on every `rise`/`fall` and increments otherwise while in HIGH or LOW.
  - When `tcnt` reaches TIMEOUT: pulse `timeout` for 1 cycle, go to IDLE, no measurement is produced.
  - An edge in the same cycle as timeout expiry takes priority: no timeout.
- **Output handshake.**
  - Completing a measurement loads `meas_high`/`meas_period`/`meas_sat` and sets `meas_valid` on the next clock edge.
  - The output is 1 cycle after the completing `rise`, i.e. SYNC_STAGES+2 cycles after the `sig_in` edge.
  - `meas_valid` and the data stay stable until `meas_valid` & `meas_ready`; `meas_valid` clears on the cycle after the transfer.
  - Transfer and a new completion in the same cycle: the new data loads and `meas_valid` stays 1.
  - New completion while `meas_valid`=1 and `meas_ready`=0:
    - the new data is dropped;
    - the held data is unchanged;
    - `overrun` is set.
  - `overrun` clears only on `clr_err`=1. If `clr_err` and a new overrun occur in the same cycle, the overrun wins.
- **Minimum measurable values.** `meas_high`=1 and `meas_period`=2 (1 cycle high, 1 cycle low).

Test Plan:
- Reset, then `en`=1. Drive `sig_in` repeatedly high 3 cycles / low 5 cycles, `meas_ready`=1 → from the 2nd rise on, a valid every 8 cycles with `meas_high`=3, `meas_period`=8, `meas_sat`=0. The first rise produces nothing.
- 1-cycle strobe every 4 cycles → `meas_high`=1, `meas_period`=4. Check first `meas_valid` latency = SYNC_STAGES+2 cycles after the second `sig_in` rise.
- `meas_ready`=0, three periods of 3/5 → first result held stable (3, 8), `overrun`=1 after the 2nd completion. `meas_ready`=1 for one cycle → `meas_valid` drops. `clr_err` → `overrun`=0.
- CNT_W=4, TIMEOUT=15: high 20 cycles → `timeout` pulse after 15 cycles with no edge, FSM back to IDLE, no valid. Repeat with high 10 / low 10 and TIMEOUT=15 → `meas_high`=10, `meas_period`=15 (saturated), `meas_sat`=1.
- Assert `reset_` low mid-HIGH with `meas_valid`=1 → all outputs 0 immediately, before the next clock. After release, the first rise only arms the block.
- Drop `en` mid-LOW, then re-enable → no spurious measurement. The next valid appears after two new rises, with correct values.
